hart_dmem_lsu: RTL
==================

Name: hart_dmem_lsu

Overview:
- Load/store unit sitting between the hart memory stage and the data-memory port. It is the initiator side of the memory ready/valid protocol.
- Converts one load/store request into a word-aligned, masked memory transaction.
- Honours o_ready back-pressure and waits for o_valid on loads.
- Returns sign/zero-extended load data plus retire-side access info, and stalls the pipeline while busy.

Parameters:
- TIMEOUT, 64: maximum cycles to wait for i_dmem_valid after load acceptance before flagging o_err; 0 disables the timeout.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_req  in  1  request strobe from memory stage; sampled only in IDLE.
- i_store  in  1  1 = store, 0 = load.
- i_funct3  in  3  RV32I width/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- i_addr  in  32  byte address.
- i_wdata  in  32  store data, right-aligned.
- o_busy  out  1  pipeline stall; high from the cycle after i_req accepted through DONE.
- o_done  out  1  one-cycle completion pulse.
- o_rdata  out  32  extended load result; valid with o_done.
- o_misaligned  out  1  with o_done: access was misaligned, no memory transaction issued.
- o_err  out  1  with o_done: load response timed out.
- o_ret_addr  out  32  word-aligned address of the access; valid with o_done.
- o_ret_mask  out  4  byte mask of the access; valid with o_done.
- o_ret_wdata  out  32  lane-shifted store data; valid with o_done.
- o_ret_rdata  out  32  raw memory word; valid with o_done.
- i_dmem_ready  in  1  memory can accept a request this cycle.
- o_dmem_addr  out  32  word-aligned address (bits [1:0] = 0).
- o_dmem_ren  out  1  read request.
- o_dmem_wen  out  1  write request.
- o_dmem_wdata  out  32  lane-shifted write data.
- o_dmem_mask  out  4  byte enables.
- i_dmem_valid  in  1  read response valid.
- i_dmem_rdata  in  32  read response word.

Behaviour:
- Reset (i_rst_n low at posedge):
  - State goes to IDLE.
  - All outputs are 0, including all 32-bit buses.
  - Timeout counter is cleared.
  - Reset mid-transaction abandons it; a late i_dmem_valid arriving in IDLE is ignored.
- Alignment and lane mapping:
  - Byte: mask = 0001 << addr[1:0].
  - Half: mask = 0011 << addr[1:0]; misaligned if addr[0] = 1.
  - Word: mask = 1111; misaligned if addr[1:0] != 0.
  - Store data is shifted left by 8*addr[1:0].
  - Load result is the raw word shifted right by 8*addr[1:0], then sign- or zero-extended per funct3.
  - Any undefined funct3 is treated as word.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - On i_req, register addr, mask, wdata, funct3 and store.
  - If misaligned, go to DONE with misaligned flagged; no memory request is made.
  - Otherwise go to ISSUE.
- ISSUE:
  - Drive ren or wen, plus addr, mask and wdata from registers, holding them stable every cycle until i_dmem_ready = 1.
  - That cycle is the acceptance. A store goes to DONE; a load goes to WAIT and clears the counter.
  - ren and wen are never both high.
- WAIT:
  - ren/wen are low.
  - On i_dmem_valid, capture i_dmem_rdata and go to DONE.
  - Otherwise the counter increments; on reaching TIMEOUT (when nonzero), go to DONE with err set and raw data = 0.
  - If valid and timeout coincide, valid wins.
- DONE:
  - o_done = 1 for exactly one cycle, then return to IDLE.
  - All result outputs are valid that cycle and are held afterwards until the next DONE.
- Stall and new requests:
  - o_busy = 1 in ISSUE, WAIT and DONE.
  - i_req is ignored unless in IDLE; a new i_req can be accepted the cycle after DONE.
- Latency:
  - Aligned store with ready high: i_req cycle t, accepted t+1, o_done t+2.
  - Load with memory latency L cycles from acceptance to valid: o_done at t+2+L.
- i_dmem_valid outside WAIT is ignored.

Decomposition:
- Shared package:
  - funct3 width constants (LB, LH, LW, LBU, LHU, SB, SH, SW).
  - FSM state encodings.
  - Mask-generation and load-extend functions, also reusable by the hart retire logic.
- One natural sub-module, lsu_align: combinational mask and store-lane generation plus load extraction/extension. The FSM lives in hart_dmem_lsu.

Test Plan:
- LW at 0x10, memory latency 4 (interval 2), word 0xDEADBEEF at 0x10 -> ren high one accepted cycle, addr 0x10, mask 1111; o_done at t+6, o_rdata 0xDEADBEEF, o_ret_mask 1111.
- LB at 0x13 and LBU at 0x13, word 0x80FF7F01 -> mask 1000; LB gives o_rdata 0xFFFFFF80, LBU gives 0x00000080.
- SH at 0x22, wdata 0x0000ABCD, i_dmem_ready low 3 cycles then high -> wen, addr 0x20, mask 1100, wdata 0xABCD0000 held stable all 4 cycles; o_done 1 cycle after acceptance.
- LW at 0x06 -> no ren/wen ever asserted; o_done at t+1 with o_misaligned = 1. SH at 0x01 gives the same result.
- Load with TIMEOUT = 8 and i_dmem_valid never asserted -> o_done with o_err = 1 exactly 8 cycles after entering WAIT; o_busy drops the cycle after.
- Reset (i_rst_n low one cycle) during WAIT, then valid arrives -> all outputs 0, state IDLE, no o_done; a following LW completes normally.

Source files
------------

// File: rtl/hart_dmem_lsu_pkg.sv
// Shared definitions for the hart data-memory load/store unit: funct3 widths,
// FSM state encodings and lane helpers (also usable by the retire logic).
package hart_dmem_lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Byte enables; any funct3 that is not a byte/half access is a full word.
  function automatic logic [3:0] lsu_mask(input logic [2:0] f3, input logic [1:0] lo);
    logic [3:0] m;
    case (f3)
      F3_LB, F3_LBU: m = 4'b0001 << lo;
      F3_LH, F3_LHU: m = 4'b0011 << lo;
      default:       m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic lsu_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    logic mis;
    case (f3)
      F3_LB, F3_LBU: mis = 1'b0;
      F3_LH, F3_LHU: mis = lo[0];
      F3_LW:         mis = (lo != 2'b00);
      default:       mis = (lo != 2'b00);
    endcase
    return mis;
  endfunction

  // Right-align the addressed lanes of the raw word, then extend.
  function automatic logic [31:0] lsu_load_extend(input logic [2:0] f3, input logic [1:0] lo,
                                                  input logic [31:0] word);
    logic [31:0] s;
    logic [31:0] r;
    s = word >> {lo, 3'b000};
    case (f3)
      F3_LB:   r = {{24{s[7]}}, s[7:0]};
      F3_LH:   r = {{16{s[15]}}, s[15:0]};
      F3_LBU:  r = {24'd0, s[7:0]};
      F3_LHU:  r = {16'd0, s[15:0]};
      default: r = s;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/hart_dmem_lsu_align.sv
// Combinational lane logic: request-side mask/misalign/store-lane shift and
// response-side load extraction with sign/zero extension.
import hart_dmem_lsu_pkg::*;

module lsu_align (
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [2:0]  i_ld_funct3,
  input  logic [1:0]  i_ld_addr_lo,
  input  logic [31:0] i_ld_word,
  output logic [3:0]  o_mask,
  output logic        o_misaligned,
  output logic [31:0] o_wdata_lane,
  output logic [31:0] o_ld_data
);

  assign o_mask       = lsu_mask(i_funct3, i_addr_lo);
  assign o_misaligned = lsu_misaligned(i_funct3, i_addr_lo);
  assign o_wdata_lane = i_wdata << {i_addr_lo, 3'b000};
  assign o_ld_data    = lsu_load_extend(i_ld_funct3, i_ld_addr_lo, i_ld_word);

endmodule

// File: rtl/hart_dmem_lsu.sv
// Load/store unit between the hart memory stage and the data-memory port.
//
//   state   | meaning
//   IDLE    | waiting for i_req; request fields captured on acceptance
//   ISSUE   | ren/wen held with stable addr/mask/wdata until i_dmem_ready
//   WAIT    | load accepted, waiting for i_dmem_valid or timeout
//   DONE    | one-cycle o_done; result outputs valid and then held
import hart_dmem_lsu_pkg::*;

module hart_dmem_lsu #(
  parameter int TIMEOUT = 64
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req,
  input  logic        i_store,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic        o_misaligned,
  output logic        o_err,
  output logic [31:0] o_ret_addr,
  output logic [3:0]  o_ret_mask,
  output logic [31:0] o_ret_wdata,
  output logic [31:0] o_ret_rdata,
  input  logic        i_dmem_ready,
  output logic [31:0] o_dmem_addr,
  output logic        o_dmem_ren,
  output logic        o_dmem_wen,
  output logic [31:0] o_dmem_wdata,
  output logic [3:0]  o_dmem_mask,
  input  logic        i_dmem_valid,
  input  logic [31:0] i_dmem_rdata
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [1:0]    r_state;
  logic [31:0]   r_addr;
  logic [1:0]    r_lo;
  logic [3:0]    r_mask;
  logic [31:0]   r_wdata;
  logic [2:0]    r_funct3;
  logic          r_store;
  logic [CW-1:0] r_cnt;

  logic [3:0]    w_mask;
  logic          w_misaligned;
  logic [31:0]   w_wdata_lane;
  logic [31:0]   w_ld_data;
  logic          w_timeout;

  lsu_align u_align (
    .i_funct3     (i_funct3),
    .i_addr_lo    (i_addr[1:0]),
    .i_wdata      (i_wdata),
    .i_ld_funct3  (r_funct3),
    .i_ld_addr_lo (r_lo),
    .i_ld_word    (i_dmem_rdata),
    .o_mask       (w_mask),
    .o_misaligned (w_misaligned),
    .o_wdata_lane (w_wdata_lane),
    .o_ld_data    (w_ld_data)
  );

  // Timeout fires when this WAIT cycle would bring the count up to TIMEOUT.
  assign w_timeout = (TIMEOUT != 0) && ((int'(r_cnt) + 1) == TIMEOUT);

  assign o_busy       = (r_state != S_IDLE);
  assign o_done       = (r_state == S_DONE);
  assign o_dmem_ren   = (r_state == S_ISSUE) && !r_store;
  assign o_dmem_wen   = (r_state == S_ISSUE) && r_store;
  assign o_dmem_addr  = r_addr;
  assign o_dmem_mask  = r_mask;
  assign o_dmem_wdata = r_wdata;

  // Request capture, handshake sequencing and result registers (held after DONE).
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_lo         <= '0;
      r_mask       <= '0;
      r_wdata      <= '0;
      r_funct3     <= '0;
      r_store      <= 1'b0;
      r_cnt        <= '0;
      o_rdata      <= '0;
      o_misaligned <= 1'b0;
      o_err        <= 1'b0;
      o_ret_addr   <= '0;
      o_ret_mask   <= '0;
      o_ret_wdata  <= '0;
      o_ret_rdata  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req) begin
            r_addr   <= {i_addr[31:2], 2'b00};
            r_lo     <= i_addr[1:0];
            r_mask   <= w_mask;
            r_wdata  <= w_wdata_lane;
            r_funct3 <= i_funct3;
            r_store  <= i_store;
            if (w_misaligned) begin
              r_state      <= S_DONE;
              o_misaligned <= 1'b1;
              o_err        <= 1'b0;
              o_rdata      <= '0;
              o_ret_addr   <= {i_addr[31:2], 2'b00};
              o_ret_mask   <= w_mask;
              o_ret_wdata  <= i_store ? w_wdata_lane : '0;
              o_ret_rdata  <= '0;
            end else begin
              r_state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (i_dmem_ready) begin
            if (r_store) begin
              r_state      <= S_DONE;
              o_misaligned <= 1'b0;
              o_err        <= 1'b0;
              o_rdata      <= '0;
              o_ret_addr   <= r_addr;
              o_ret_mask   <= r_mask;
              o_ret_wdata  <= r_wdata;
              o_ret_rdata  <= '0;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= '0;
            end
          end
        end
        S_WAIT: begin
          if (i_dmem_valid || w_timeout) begin
            r_state      <= S_DONE;
            o_misaligned <= 1'b0;
            o_err        <= !i_dmem_valid;
            o_rdata      <= i_dmem_valid ? w_ld_data : '0;
            o_ret_addr   <= r_addr;
            o_ret_mask   <= r_mask;
            o_ret_wdata  <= '0;
            o_ret_rdata  <= i_dmem_valid ? i_dmem_rdata : '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
